// File: rtl/elixirchip_es1_spu_ctl_enable_gen.sv
// ---------------------------------------------------------------------------
// elixirchip_es1_spu_ctl_enable_gen
//
// Per-beat enable generator for the SPU valid-mask stage. After a start pulse
// it suppresses s_skip beats, then enables s_pass beats, and repeats that
// period s_repeat times (0 = forever). It also emits a pre-masked valid,
// (s_valid & m_enable), delayed by LATENCY clock-enabled register stages.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   cke             clock enable; no state (including m_valid stages) moves
//                   while cke=0
//   s_start         start pulse, latches s_skip/s_pass/s_repeat (IDLE only)
//   s_stop          abort back to IDLE without m_done
//   s_skip/s_pass   beats suppressed / enabled per period
//   s_repeat        number of periods, 0 = run until s_stop
//   s_valid         upstream beat valid (beat = cke & s_valid)
//   m_enable        1 while the current beat is to be passed (state==PASS)
//   m_valid         (s_valid & m_enable) delayed LATENCY cke cycles
//   m_busy          1 when not IDLE
//   m_done          one-cke-cycle pulse after the final passed beat
//   dbg_state       FSM state (0 IDLE, 1 SKIP, 2 PASS); tied to 0 on device
//                   builds unless DEBUG or SIMULATION is "true"
//
// Handshake: there is no backpressure. A beat is consumed on every rising
// clk edge where cke=1 and s_valid=1; it is passed downstream when m_enable
// is also high in that same cycle. s_start/s_stop are sampled only on cke=1.
// ---------------------------------------------------------------------------
module elixirchip_es1_spu_ctl_enable_gen #(
  parameter int COUNTER_BITS = 16,
  parameter int LATENCY      = 1,
  parameter     DEVICE       = "RTL",
  parameter     SIMULATION   = "false",
  parameter     DEBUG        = "false"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cke,
  input  logic                    s_start,
  input  logic                    s_stop,
  input  logic [COUNTER_BITS-1:0] s_skip,
  input  logic [COUNTER_BITS-1:0] s_pass,
  input  logic [COUNTER_BITS-1:0] s_repeat,
  input  logic                    s_valid,
  output logic                    m_enable,
  output logic                    m_valid,
  output logic                    m_busy,
  output logic                    m_done,
  output logic [1:0]              dbg_state
);

  localparam logic [COUNTER_BITS-1:0] ONE = COUNTER_BITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_PASS = 2'd2
  } state_t;

  state_t                  state;
  logic [COUNTER_BITS-1:0] skip_len;  // latched period shape, used on reload
  logic [COUNTER_BITS-1:0] pass_len;
  logic                    rep_inf;   // latched s_repeat == 0
  logic [COUNTER_BITS-1:0] skip_cnt;
  logic [COUNTER_BITS-1:0] pass_cnt;
  logic [COUNTER_BITS-1:0] rep_cnt;
  logic                    pass_beat;

  assign m_enable  = (state == ST_PASS);
  assign m_busy    = (state != ST_IDLE);
  assign pass_beat = s_valid & m_enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_len <= '0;
      pass_len <= '0;
      rep_inf  <= 1'b0;
      skip_cnt <= '0;
      pass_cnt <= '0;
      rep_cnt  <= '0;
      m_done   <= 1'b0;
    end else if (cke) begin
      // m_done only changes on cke cycles, so a pulse stretches across any
      // cke=0 gap and lasts exactly one enabled cycle.
      m_done <= 1'b0;
      if (s_stop) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (s_start) begin
              if (s_pass == '0) begin
                // Nothing would ever be passed: finish immediately.
                m_done <= 1'b1;
              end else begin
                skip_len <= s_skip;
                pass_len <= s_pass;
                rep_inf  <= (s_repeat == '0);
                skip_cnt <= s_skip;
                pass_cnt <= s_pass;
                rep_cnt  <= s_repeat;
                state    <= (s_skip != '0) ? ST_SKIP : ST_PASS;
              end
            end
          end

          ST_SKIP: begin
            if (s_valid) begin
              // <= ONE also covers a zero count so we never wrap below 0.
              if (skip_cnt <= ONE) begin
                skip_cnt <= '0;
                pass_cnt <= pass_len;
                state    <= ST_PASS;
              end else begin
                skip_cnt <= skip_cnt - ONE;
              end
            end
          end

          ST_PASS: begin
            if (s_valid) begin
              if (pass_cnt > ONE) begin
                pass_cnt <= pass_cnt - ONE;
              end else if (rep_inf || (rep_cnt > ONE)) begin
                // Period complete, another one follows.
                if (!rep_inf) begin
                  rep_cnt <= rep_cnt - ONE;
                end
                skip_cnt <= skip_len;
                pass_cnt <= pass_len;
                state    <= (skip_len != '0) ? ST_SKIP : ST_PASS;
              end else begin
                // Last passed beat of the last period.
                pass_cnt <= '0;
                rep_cnt  <= '0;
                state    <= ST_IDLE;
                m_done   <= 1'b1;
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Masked valid pipeline; stages hold while cke=0 and clear on reset so no
  // in-flight valid survives a mid-run reset.
  generate
    if (LATENCY <= 0) begin : g_lat_comb
      assign m_valid = pass_beat;
    end else begin : g_lat_pipe
      logic [LATENCY-1:0] vpipe;
      always_ff @(posedge clk) begin
        if (reset) begin
          vpipe <= '0;
        end else if (cke) begin
          vpipe[0] <= pass_beat;
          for (int i = 1; i < LATENCY; i++) begin
            vpipe[i] <= vpipe[i-1];
          end
        end
      end
      assign m_valid = vpipe[LATENCY-1];
    end
  endgenerate

  // The behavioural model and debug/simulation builds export the FSM state;
  // device builds tie it off.
  generate
    if ((DEBUG == "true") || (SIMULATION == "true") || (DEVICE == "RTL")) begin : g_dbg_on
      assign dbg_state = state;
    end else begin : g_dbg_off
      assign dbg_state = 2'd0;
    end
  endgenerate

endmodule

// File: tb/tb_elixirchip_es1_spu_ctl_enable_gen.sv
// ---------------------------------------------------------------------------
// Directed bench for elixirchip_es1_spu_ctl_enable_gen. Two instances share
// the stimulus: u_dut (LATENCY=1) and u_dut3 (LATENCY=3). Inputs are driven
// 1 time unit after the rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_elixirchip_es1_spu_ctl_enable_gen;

  localparam int CB = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          cke;
  logic          s_start;
  logic          s_stop;
  logic [CB-1:0] s_skip;
  logic [CB-1:0] s_pass;
  logic [CB-1:0] s_repeat;
  logic          s_valid;

  logic       m_enable, m_valid, m_busy, m_done;
  logic [1:0] dbg_state;
  logic       m3_enable, m3_valid, m3_busy, m3_done;
  logic [1:0] dbg3_state;

  elixirchip_es1_spu_ctl_enable_gen #(.COUNTER_BITS(CB), .LATENCY(1)) u_dut (
    .clk(clk), .reset(reset), .cke(cke), .s_start(s_start), .s_stop(s_stop),
    .s_skip(s_skip), .s_pass(s_pass), .s_repeat(s_repeat), .s_valid(s_valid),
    .m_enable(m_enable), .m_valid(m_valid), .m_busy(m_busy), .m_done(m_done),
    .dbg_state(dbg_state)
  );

  elixirchip_es1_spu_ctl_enable_gen #(.COUNTER_BITS(CB), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .cke(cke), .s_start(s_start), .s_stop(s_stop),
    .s_skip(s_skip), .s_pass(s_pass), .s_repeat(s_repeat), .s_valid(s_valid),
    .m_enable(m3_enable), .m_valid(m3_valid), .m_busy(m3_busy), .m_done(m3_done),
    .dbg_state(dbg3_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input int skip, input int pass, input int rep);
    s_skip   = CB'(skip);
    s_pass   = CB'(pass);
    s_repeat = CB'(rep);
    s_start  = 1'b1;
    tick();
    s_start  = 1'b0;
  endtask

  // skip=2 pass=3 repeat=2 with valid every cycle. k counts cycles after the
  // start edge; beat k happens on the edge following the k-th sample.
  // Passed beats: 2-4 and 7-9. With inject=1 a second start with other
  // parameters arrives during beat 3 and must be ignored.
  task automatic run_pattern(input bit inject, input string nm);
    logic exp_en, exp_mv, exp_mv3, exp_done, exp_busy;
    logic [1:0] exp_st;
    cke     = 1'b1;
    s_valid = 1'b1;
    start_run(2, 3, 2);
    for (int k = 0; k < 14; k++) begin
      exp_en   = (k >= 2 && k <= 4) || (k >= 7 && k <= 9);
      exp_mv   = (k >= 3 && k <= 5) || (k >= 8 && k <= 10);
      exp_mv3  = (k >= 5 && k <= 7) || (k >= 10 && k <= 12);
      exp_done = (k == 10);
      exp_busy = (k <= 9);
      exp_st   = !exp_busy ? 2'd0 : (exp_en ? 2'd2 : 2'd1);
      check($sformatf("%s k=%0d enable", nm, k), m_enable, exp_en);
      check($sformatf("%s k=%0d valid", nm, k), m_valid, exp_mv);
      check($sformatf("%s k=%0d valid_l3", nm, k), m3_valid, exp_mv3);
      check($sformatf("%s k=%0d done", nm, k), m_done, exp_done);
      check($sformatf("%s k=%0d done_l3", nm, k), m3_done, exp_done);
      check($sformatf("%s k=%0d busy", nm, k), m_busy, exp_busy);
      check($sformatf("%s k=%0d state", nm, k), dbg_state, exp_st);
      if (inject && k == 3) begin
        s_skip   = CB'(0);
        s_pass   = CB'(7);
        s_repeat = CB'(5);
        s_start  = 1'b1;
      end else begin
        s_start  = 1'b0;
      end
      tick();
    end
    s_start = 1'b0;
  endtask

  initial begin
    int   b;
    int   pulses;
    int   dones;
    logic fresh;
    logic exp_en, exp_mv, exp_done;

    reset    = 1'b1;
    cke      = 1'b0;
    s_start  = 1'b0;
    s_stop   = 1'b0;
    s_skip   = '0;
    s_pass   = '0;
    s_repeat = '0;
    s_valid  = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset state
    check("reset enable", m_enable, 1'b0);
    check("reset valid", m_valid, 1'b0);
    check("reset valid_l3", m3_valid, 1'b0);
    check("reset busy", m_busy, 1'b0);
    check("reset done", m_done, 1'b0);
    check("reset state", dbg_state, 2'd0);

    // basic skip/pass/repeat pattern
    run_pattern(1'b0, "t1");

    // second start mid-run is ignored
    run_pattern(1'b1, "t6");

    // skip=0 pass=1 repeat=0: enable stuck high until s_stop
    cke     = 1'b1;
    s_valid = 1'b1;
    start_run(0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t2 k=%0d enable", k), m_enable, 1'b1);
      check($sformatf("t2 k=%0d busy", k), m_busy, 1'b1);
      check($sformatf("t2 k=%0d done", k), m_done, 1'b0);
      check($sformatf("t2 k=%0d valid", k), m_valid, (k >= 1));
      tick();
    end
    s_stop = 1'b1;
    tick();
    s_stop = 1'b0;
    check("t2 stop busy", m_busy, 1'b0);
    check("t2 stop enable", m_enable, 1'b0);
    check("t2 stop done", m_done, 1'b0);
    check("t2 stop beat still passed", m_valid, 1'b1);
    tick();
    check("t2 after stop done", m_done, 1'b0);
    check("t2 after stop valid", m_valid, 1'b0);

    // skip=1 pass=2 repeat=1, valid toggling, cke randomly low.
    // Bench model: b counts beats since start; beats 1 and 2 are passed.
    cke     = 1'b1;
    s_valid = 1'b0;
    start_run(1, 2, 1);
    b        = 0;
    pulses   = 0;
    dones    = 0;
    exp_mv   = 1'b0;
    exp_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      s_valid = (i % 2 == 0);
      cke     = (i >= 30) ? 1'b1 : ($urandom_range(0, 3) != 0);
      exp_en  = (b == 1 || b == 2);
      check($sformatf("t3 i=%0d enable", i), m_enable, exp_en);
      fresh = cke;
      if (cke) begin
        exp_mv   = s_valid & exp_en;
        exp_done = s_valid && (b == 2);
        if (s_valid) b++;
      end
      tick();
      check($sformatf("t3 i=%0d valid", i), m_valid, exp_mv);
      check($sformatf("t3 i=%0d done", i), m_done, exp_done);
      check($sformatf("t3 i=%0d busy", i), m_busy, (b < 3));
      if (fresh && m_valid) pulses++;
      if (fresh && m_done) dones++;
    end
    check("t3 valid pulse count", pulses, 2);
    check("t3 done pulse count", dones, 1);

    // pass=0: never busy, done one cycle after start
    cke      = 1'b1;
    s_valid  = 1'b1;
    s_skip   = CB'(4);
    s_pass   = CB'(0);
    s_repeat = CB'(3);
    s_start  = 1'b1;
    check("t4 pre busy", m_busy, 1'b0);
    check("t4 pre done", m_done, 1'b0);
    tick();
    s_start = 1'b0;
    check("t4 busy", m_busy, 1'b0);
    check("t4 done", m_done, 1'b1);
    check("t4 enable", m_enable, 1'b0);
    tick();
    check("t4 done clears", m_done, 1'b0);
    check("t4 busy after", m_busy, 1'b0);

    // reset in PASS with the LATENCY=3 pipeline full
    cke     = 1'b1;
    s_valid = 1'b1;
    start_run(0, 5, 1);
    repeat (3) tick();
    check("t5 pre valid_l3", m3_valid, 1'b1);
    check("t5 pre enable", m3_enable, 1'b1);
    reset = 1'b1;
    tick();
    check("t5 rst enable", m_enable, 1'b0);
    check("t5 rst valid", m_valid, 1'b0);
    check("t5 rst busy", m_busy, 1'b0);
    check("t5 rst done", m_done, 1'b0);
    check("t5 rst enable_l3", m3_enable, 1'b0);
    check("t5 rst valid_l3", m3_valid, 1'b0);
    check("t5 rst busy_l3", m3_busy, 1'b0);
    check("t5 rst done_l3", m3_done, 1'b0);
    check("t5 rst state_l3", dbg3_state, 2'd0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t5 post k=%0d valid_l3", k), m3_valid, 1'b0);
      check($sformatf("t5 post k=%0d valid", k), m_valid, 1'b0);
      check($sformatf("t5 post k=%0d busy_l3", k), m3_busy, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
